// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: ID operand forwarding, load-use stalls,
// redirect flushes and per-stage valid tracking. Optional counters under PIPE_PERF_CNT_EN.
//
// state     | meaning
// ST_RUN    | normal issue; a load-use hazard stalls here for one cycle
// ST_LDWAIT | extra stall cycles while a multi-cycle load completes in MEM
module pipe_hazard_ctrl #(
  parameter int XLEN     = 32,
  parameter int NRD      = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  input  logic [NRD*5-1:0]     id_rs,
  input  logic [NRD-1:0]       id_rs_used,
  input  logic [NRD*XLEN-1:0]  rf_rdata,
  input  logic                 ex_we,
  input  logic [4:0]           ex_wr,
  input  logic                 ex_is_load,
  input  logic [XLEN-1:0]      ex_wd,
  input  logic                 ex_redirect,
  input  logic                 mem_we,
  input  logic [4:0]           mem_wr,
  input  logic                 mem_is_load,
  input  logic [XLEN-1:0]      mem_wd,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 wb_we,
  input  logic [4:0]           wb_wr,
  input  logic [XLEN-1:0]      wb_wd,
  output logic [NRD*XLEN-1:0]  id_rdata,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [3:0]           stage_vld,
  output logic                 wb_retire
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycle,
  output logic [31:0]          perf_retire,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_flush
`endif
);

  typedef enum logic {ST_RUN, ST_LDWAIT} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LOAD_LAT - 1);

  state_t         state, state_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic [3:0]     vld;
  logic [NRD-1:0] port_haz;
  logic           haz;

  assign stage_vld = vld;
  assign wb_retire = vld[3];

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [4:0]      rs;
    logic [XLEN-1:0] raw;
    logic            ex_hit, mem_hit, wb_hit;

    assign rs      = id_rs[5*k +: 5];
    assign raw     = rf_rdata[XLEN*k +: XLEN];
    assign ex_hit  = vld[1] & ex_we  & (ex_wr  == rs);
    assign mem_hit = vld[2] & mem_we & (mem_wr == rs);
    assign wb_hit  = vld[3] & wb_we  & (wb_wr  == rs);

    // A load still in EX has no data yet; the stall covers that case, so no bypass here.
    assign id_rdata[XLEN*k +: XLEN] =
      (rs == 5'd0) ? raw :
      ex_hit       ? (ex_is_load ? raw : ex_wd) :
      mem_hit      ? (mem_is_load ? mem_rdata : mem_wd) :
      wb_hit       ? wb_wd : raw;

    assign port_haz[k] = id_rs_used[k] & ex_hit & ex_is_load & (rs != 5'd0);
  end

  assign haz = |port_haz;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= ST_RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ex_redirect) begin
      state_nxt = ST_RUN;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (haz && (LOAD_LAT > 1)) begin
            state_nxt = ST_LDWAIT;
            cnt_nxt   = LAT_M1;
          end
        end
        ST_LDWAIT: begin
          if (cnt == 8'd1) begin
            state_nxt = ST_RUN;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (cpu_rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((state == ST_LDWAIT) || haz) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      vld <= 4'b0000;
    end else begin
      vld[0] <= if_id_flush ? 1'b0 : (if_id_en ? 1'b1 : vld[0]);
      vld[1] <= vld[0] & ~id_ex_flush;
      vld[2] <= vld[1];
      vld[3] <= vld[2];
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      perf_cycle  <= 32'd0;
      perf_retire <= 32'd0;
      perf_stall  <= 32'd0;
      perf_flush  <= 32'd0;
    end else begin
      perf_cycle  <= perf_cycle + 32'd1;
      perf_retire <= perf_retire + 32'(wb_retire);
      perf_stall  <= perf_stall + 32'(~pc_en);
      perf_flush  <= perf_flush + 32'(ex_redirect);
    end
  end
`endif

endmodule
